ticket_printer_arbiter: RTL
===========================

// Module: ticket_printer_arbiter
// PURPOSE
//   Shares the single ticket printer among N_LANES entry-lane ticket FSMs. Each lane raises a print
//   request; the block grants one lane at a time (round-robin), issues printer_cmd with the next ticket
//   serial, waits for printer completion or timeout, and reports done/fail back to the owning lane.
//   Takes the printer out of service while paper is empty.
// PARAMETERS
//   N_LANES          4        number of entry lanes sharing the printer (>=2)
//   SERIAL_W         16       ticket serial number width
//   PRINT_TIMEOUT    500000   cycles allowed from printer_cmd to printer_ack (5 ms @ 100 MHz)
// PORTS
//   clk              in   1          system clock
//   reset_n          in   1          asynchronous reset, active-low
//   lane_req         in   N_LANES    per-lane print request, level, held until lane_done/lane_fail
//   lane_grant       out  N_LANES    one-hot owner of printer, held GRANT..RELEASE inclusive
//   lane_done        out  N_LANES    1-cycle pulse to owner: ticket printed
//   lane_fail        out  N_LANES    1-cycle pulse to owner: print timed out or printer out of service
//   printer_cmd      out  1          1-cycle pulse: start printing printer_serial
//   printer_serial   out  SERIAL_W   serial to print; stable from printer_cmd until RELEASE
//   printer_ack      in   1          1-cycle pulse from printer: ticket complete
//   paper_empty      in   1          level, printer out of paper
//   out_of_service   out  1          high in FAULT; drives all lanes' out-of-service lamps
//   serial_count     out  SERIAL_W   tickets issued since reset (== next serial)
// BEHAVIOUR
//   - Reset value of every output: 0; rr pointer -> lane 0; serial -> 0; timer -> 0; state -> IDLE.
//   - All outputs registered. States: IDLE, GRANT, PRINTING, RELEASE, FAULT.
//   - IDLE: paper_empty=1 -> FAULT (priority over requests). Else any lane_req -> GRANT; winner = first
//     requesting lane searching upward from rr pointer, wrapping N_LANES-1 -> 0.
//   - GRANT (1 cycle): lane_grant=onehot(winner), printer_cmd=1, printer_serial=serial, timer cleared.
//     Latency: req sampled in IDLE cycle t -> grant+printer_cmd visible cycle t+1.
//   - PRINTING: timer increments each cycle. printer_ack -> RELEASE(ok). timer==PRINT_TIMEOUT-1 without
//     ack -> RELEASE(fail). Ack and timeout in same cycle: ack wins.
//   - RELEASE (1 cycle): ok -> lane_done[winner]=1, serial+1 (wraps 2^SERIAL_W-1 -> 0); fail ->
//     lane_fail[winner]=1, serial unchanged. rr pointer <- winner+1 mod N_LANES. Next: paper_empty ->
//     FAULT, else IDLE. lane_grant drops the cycle after RELEASE.
//   - Requester drops lane_req mid-print: job still completes; done/fail still pulsed to that lane.
//   - paper_empty rising during GRANT/PRINTING: current job finishes normally (ack or timeout) first.
//   - FAULT: out_of_service=1, no grants; every lane with lane_req=1 gets one lane_fail pulse on FAULT
//     entry, and on any new rising lane_req while in FAULT. Exit to IDLE on first cycle paper_empty=0;
//     out_of_service deasserts that cycle+1.
//   - printer_ack outside PRINTING is ignored. At most one lane_done/lane_fail bit set, except FAULT
//     fan-out of lane_fail.
//   - Reset mid-operation: everything returns to reset values immediately; in-flight job is lost,
//     no done/fail pulsed.
// STRUCTURE
//   - garage_pkg: typedef enum logic [2:0] prn_state_t {IDLE, GRANT, PRINTING, RELEASE, FAULT};
//     shared default constants (CLOCK_MHZ, PRINT_TIMEOUT default); shared with ticket_fsm lane logic.
//   - Sub-module rr_arbiter #(N): combinational; inputs req, pointer; outputs one-hot grant + index,
//     valid. Timer width = $clog2(PRINT_TIMEOUT+1).
// TESTING (bench overrides PRINT_TIMEOUT=20, N_LANES=4)
//   1. lane_req=0001, ack 5 cyc after cmd -> grant=0001 next cycle, printer_serial=0, lane_done[0]; serial_count=1.
//   2. lane_req=1111 held, ack each job -> grants in order 0,1,2,3,0; serials 0,1,2,3,4.
//   3. req lane 2, no ack -> lane_fail[2] exactly 20 cyc after cmd; serial_count unchanged; next grant lane 3.
//   4. paper_empty=1 in IDLE with req=0110 -> out_of_service=1, lane_fail=0110 once, no printer_cmd;
//      paper_empty=0 -> IDLE, lane 1 granted.
//   5. paper_empty rises mid-print, then ack -> lane_done pulsed, then FAULT; ack with timer==19 same cycle -> done.
//   6. Preload serial 16'hFFFF via 65535 fast jobs (or force) -> next ok gives serial_count=0; reset_n mid-PRINTING
//      -> all outputs 0 next edge, no done/fail.

Source files
------------

// File: rtl/garage_pkg.sv
// Shared garage types and defaults: printer FSM states, clock rate,
// default print timeout. Used by the printer arbiter and lane logic.
package garage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    PRINTING,
    RELEASE,
    FAULT
  } prn_state_t;

  localparam int CLOCK_MHZ = 100;
  // 5 ms at CLOCK_MHZ
  localparam int PRINT_TIMEOUT_DFLT = CLOCK_MHZ * 5000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr,
// wrapping. Ports: req, ptr in; grant (one-hot), idx, valid out.
module rr_arbiter
  import garage_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ticket_printer_arbiter.sv
// Shares one ticket printer among N_LANES lanes: round-robin grant,
// printer_cmd/serial, ack or timeout, done/fail to owner, FAULT on no paper.
// Ports: clk, reset_n, lane_req/grant/done/fail, printer_cmd/serial/ack,
// paper_empty, out_of_service, serial_count.
module ticket_printer_arbiter
  import garage_pkg::*;
#(
  parameter int N_LANES       = 4,
  parameter int SERIAL_W      = 16,
  parameter int PRINT_TIMEOUT = PRINT_TIMEOUT_DFLT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_LANES-1:0]  lane_req,
  output logic [N_LANES-1:0]  lane_grant,
  output logic [N_LANES-1:0]  lane_done,
  output logic [N_LANES-1:0]  lane_fail,
  output logic                printer_cmd,
  output logic [SERIAL_W-1:0] printer_serial,
  input  logic                printer_ack,
  input  logic                paper_empty,
  output logic                out_of_service,
  output logic [SERIAL_W-1:0] serial_count
);

  localparam int IW = $clog2(N_LANES);
  localparam int TW = $clog2(PRINT_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(PRINT_TIMEOUT - 1);
  localparam logic [IW-1:0] W_LAST = IW'(N_LANES - 1);

  prn_state_t          state, state_n;
  logic [IW-1:0]       rr_ptr, rr_n;
  logic [IW-1:0]       win, win_n;
  logic [TW-1:0]       timer, timer_n;
  logic [SERIAL_W-1:0] serial_n, pserial_n;
  logic [N_LANES-1:0]  seen, seen_n;
  logic [N_LANES-1:0]  grant_n, done_n, fail_n;
  logic                cmd_n, oos_n;

  logic [N_LANES-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;

  rr_arbiter #(.N(N_LANES), .IW(IW)) u_arb (
    .req   (lane_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      win            <= '0;
      timer          <= '0;
      seen           <= '0;
      serial_count   <= '0;
      printer_serial <= '0;
      lane_grant     <= '0;
      lane_done      <= '0;
      lane_fail      <= '0;
      printer_cmd    <= 1'b0;
      out_of_service <= 1'b0;
    end else begin
      state          <= state_n;
      rr_ptr         <= rr_n;
      win            <= win_n;
      timer          <= timer_n;
      seen           <= seen_n;
      serial_count   <= serial_n;
      printer_serial <= pserial_n;
      lane_grant     <= grant_n;
      lane_done      <= done_n;
      lane_fail      <= fail_n;
      printer_cmd    <= cmd_n;
      out_of_service <= oos_n;
    end
  end

  always_comb begin
    state_n   = state;
    rr_n      = rr_ptr;
    win_n     = win;
    timer_n   = timer;
    seen_n    = seen;
    serial_n  = serial_count;
    pserial_n = printer_serial;
    grant_n   = lane_grant;
    done_n    = '0;
    fail_n    = '0;
    cmd_n     = 1'b0;
    oos_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (paper_empty) begin
          state_n = FAULT;
          oos_n   = 1'b1;
          fail_n  = lane_req;
          seen_n  = lane_req;
        end else if (arb_valid) begin
          state_n   = GRANT;
          win_n     = arb_idx;
          grant_n   = arb_grant;
          cmd_n     = 1'b1;
          pserial_n = serial_count;
          timer_n   = '0;
        end
      end
      // timer counts cycles since printer_cmd
      GRANT: begin
        state_n = PRINTING;
        timer_n = timer + TW'(1);
      end
      PRINTING: begin
        timer_n = timer + TW'(1);
        if (printer_ack) begin
          state_n  = RELEASE;
          done_n   = lane_grant;
          serial_n = serial_count + SERIAL_W'(1);
        end else if (timer == T_LAST) begin
          state_n = RELEASE;
          fail_n  = lane_grant;
        end
      end
      RELEASE: begin
        rr_n    = (win == W_LAST) ? '0 : win + IW'(1);
        grant_n = '0;
        if (paper_empty) begin
          // owner was just answered; only other waiters get fail
          state_n = FAULT;
          oos_n   = 1'b1;
          fail_n  = lane_req & ~lane_grant;
          seen_n  = lane_req;
        end else begin
          state_n = IDLE;
        end
      end
      FAULT: begin
        if (paper_empty) begin
          // fail each newly rising request once
          oos_n  = 1'b1;
          fail_n = lane_req & ~seen;
          seen_n = lane_req;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
